// File: rtl/alu_operations_pkg.sv
// ALU operation encoding shared by the decode/issue stage and the ALU.
package alu_operations;

    typedef enum logic [3:0] {
        Add                    = 4'd0,
        Subtract               = 4'd1,
        Shift_Left_Logical     = 4'd2,
        Set_Less_Than          = 4'd3,
        Set_Less_Than_Unsigned = 4'd4,
        Xor                    = 4'd5,
        Shift_Right_Logical    = 4'd6,
        Shift_Right_Arithmetic = 4'd7,
        Or                     = 4'd8,
        And                    = 4'd9
    } alu_operation_t;

endpackage

// File: rtl/riscv_opcodes_pkg.sv
// RV32I opcode/funct7 constants and the decoded entry held by the issue stage.
package riscv_opcodes;

    import alu_operations::*;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_operation_t operation;
        logic [31:0]    operand_1;
        logic [31:0]    operand_2;
        logic [4:0]     rd;
        logic           write_enable;
        logic           illegal;
    } issue_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } issue_state_t;

    // Operation selected by funct3 when funct7 carries no alternate encoding.
    function automatic alu_operation_t base_operation(input logic [2:0] funct3);
        alu_operation_t op;
        case (funct3)
            3'b000:  op = Add;
            3'b001:  op = Shift_Left_Logical;
            3'b010:  op = Set_Less_Than;
            3'b011:  op = Set_Less_Than_Unsigned;
            3'b100:  op = Xor;
            3'b101:  op = Shift_Right_Logical;
            3'b110:  op = Or;
            3'b111:  op = And;
            default: op = Add;
        endcase
        return op;
    endfunction

    function automatic issue_entry_t reset_entry();
        issue_entry_t e;
        e           = '0;
        e.operation = Add;
        return e;
    endfunction

endpackage

// File: rtl/immediate_generator.sv
// Extracts the I-type immediate, U-type immediate and shift amount from an instruction.
module immediate_generator (
    input  logic [31:0] instruction,
    output logic [31:0] imm_i,
    output logic [31:0] imm_u,
    output logic [4:0]  shamt
);

    logic unused_low_bits_s;

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_u = {instruction[31:12], 12'd0};
    assign shamt = instruction[24:20];

    assign unused_low_bits_s = ^instruction[11:0];

endmodule

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes ALU instructions and presents them to the ALU
// through a two-entry skid buffer so back-pressure never loses an instruction.
module alu_issue
    import alu_operations::*;
    import riscv_opcodes::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instruction,
    input  logic [XLEN-1:0]           pc,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output alu_operation_t            operation,
    output logic [XLEN-1:0]           operand_1,
    output logic [XLEN-1:0]           operand_2,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      write_enable,
    output logic                      illegal
);

    logic [6:0]   opcode_s;
    logic [2:0]   funct3_s;
    logic [6:0]   funct7_s;
    logic [31:0]  imm_i_s;
    logic [31:0]  imm_u_s;
    logic [4:0]   shamt_s;
    issue_entry_t decoded_s;

    issue_state_t state_r;
    issue_state_t state_next_s;
    issue_entry_t main_r;
    issue_entry_t skid_r;
    logic         in_ready_s;
    logic         out_valid_s;
    logic         accept_s;
    logic         consume_s;
    logic         load_main_s;
    logic         load_skid_s;
    logic         main_from_skid_s;

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];

    immediate_generator u_immediate_generator (
        .instruction (instruction),
        .imm_i       (imm_i_s),
        .imm_u       (imm_u_s),
        .shamt       (shamt_s)
    );

    // Instruction decode into the entry that will be stored in the buffer.
    always_comb begin
        decoded_s    = reset_entry();
        decoded_s.rd = instruction[11:7];
        case (opcode_s)
            OPCODE_OP: begin
                decoded_s.operand_1 = rs1_data;
                decoded_s.operand_2 = rs2_data;
                if (funct7_s == FUNCT7_BASE) begin
                    decoded_s.operation = base_operation(funct3_s);
                end else if ((funct7_s == FUNCT7_ALT) && (funct3_s == 3'b000)) begin
                    decoded_s.operation = Subtract;
                end else if ((funct7_s == FUNCT7_ALT) && (funct3_s == 3'b101)) begin
                    decoded_s.operation = Shift_Right_Arithmetic;
                end else begin
                    decoded_s.illegal = 1'b1;
                end
            end
            OPCODE_OP_IMM: begin
                decoded_s.operand_1 = rs1_data;
                if (funct3_s == 3'b001) begin
                    decoded_s.operand_2 = {27'd0, shamt_s};
                    decoded_s.operation = Shift_Left_Logical;
                    decoded_s.illegal   = (funct7_s != FUNCT7_BASE);
                end else if (funct3_s == 3'b101) begin
                    decoded_s.operand_2 = {27'd0, shamt_s};
                    if (funct7_s == FUNCT7_BASE) begin
                        decoded_s.operation = Shift_Right_Logical;
                    end else if (funct7_s == FUNCT7_ALT) begin
                        decoded_s.operation = Shift_Right_Arithmetic;
                    end else begin
                        decoded_s.illegal = 1'b1;
                    end
                end else begin
                    // ADDI has no SUBI counterpart, so funct7 bits are immediate here
                    decoded_s.operand_2 = imm_i_s;
                    decoded_s.operation = base_operation(funct3_s);
                end
            end
            OPCODE_LUI: begin
                decoded_s.operand_2 = imm_u_s;
            end
            OPCODE_AUIPC: begin
                decoded_s.operand_1 = pc;
                decoded_s.operand_2 = imm_u_s;
            end
            default: begin
                decoded_s.illegal = 1'b1;
            end
        endcase
        decoded_s.write_enable = !decoded_s.illegal && (decoded_s.rd != 5'd0);
    end

    // Buffer occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign accept_s  = in_valid && in_ready_s;
    assign consume_s = out_valid_s && out_ready;

    // Next-state and buffer load selection.
    always_comb begin
        state_next_s     = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    load_main_s  = 1'b1;
                    state_next_s = ONE;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && consume_s) begin
                    load_main_s  = 1'b1;
                    state_next_s = ONE;
                end else if (accept_s) begin
                    load_skid_s  = 1'b1;
                    state_next_s = FULL;
                end else if (consume_s) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ONE;
                end
            end
            FULL: begin
                if (consume_s) begin
                    main_from_skid_s = 1'b1;
                    state_next_s     = ONE;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // Handshake outputs decoded purely from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            EMPTY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ONE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b1;
            end
            FULL: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Main (ALU-facing) and skid entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= reset_entry();
            skid_r <= reset_entry();
        end else begin
            if (main_from_skid_s) begin
                main_r <= skid_r;
            end else if (load_main_s) begin
                main_r <= decoded_s;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= decoded_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_s;
    assign operation    = main_r.operation;
    assign operand_1    = main_r.operand_1;
    assign operand_2    = main_r.operand_2;
    assign rd           = main_r.rd;
    assign write_enable = main_r.write_enable;
    assign illegal      = main_r.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, back-pressure and reset
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_alu_issue;

    import alu_operations::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [31:0]    instruction = 32'd0;
    logic [31:0]    pc = 32'd0;
    logic [31:0]    rs1_data = 32'd0;
    logic [31:0]    rs2_data = 32'd0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    alu_operation_t operation;
    logic [31:0]    operand_1;
    logic [31:0]    operand_2;
    logic [4:0]     rd;
    logic           write_enable;
    logic           illegal;

    alu_issue #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
        .operand_1(operand_1), .operand_2(operand_2), .rd(rd),
        .write_enable(write_enable), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_operation_t op;
        logic [31:0]    op1;
        logic [31:0]    op2;
        logic [4:0]     rd;
        logic           we;
        logic           ill;
        logic           care;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        exp_t        e;
    } vec_t;

    exp_t           q[$];
    logic [4:0]     popped[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    alu_operation_t op_table[8] = '{Add, Shift_Left_Logical, Set_Less_Than, Set_Less_Than_Unsigned,
                                    Xor, Shift_Right_Logical, Or, And};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic [31:0] uimm = {ins[31:12], 12'd0};
        e.op = Add; e.op1 = 32'd0; e.op2 = 32'd0; e.rd = ins[11:7]; e.ill = 1'b0; e.care = 1'b1;
        case (ins[6:0])
            7'h33: begin
                e.op1 = r1; e.op2 = r2;
                if (f7 == 7'h00) e.op = op_table[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.op = Subtract;
                else if (f7 == 7'h20 && f3 == 3'd5) e.op = Shift_Right_Arithmetic;
                else e.ill = 1'b1;
            end
            7'h13: begin
                e.op1 = r1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.op2 = 32'(ins[24:20]);
                    e.op  = op_table[f3];
                    if (f7 == 7'h20 && f3 == 3'd5) e.op = Shift_Right_Arithmetic;
                    else if (f7 != 7'h00) e.ill = 1'b1;
                end else begin
                    e.op2 = 32'($signed(ins[31:20]));
                    e.op  = op_table[f3];
                end
            end
            7'h37: e.op2 = uimm;
            7'h17: begin e.op1 = p; e.op2 = uimm; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill && (ins[6:0] == 7'h33 || ins[6:0] == 7'h13)) e.care = 1'b0;
        e.we = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("rd", 32'(rd), 32'(q[0].rd));
            chk("write_enable", 32'(write_enable), 32'(q[0].we));
            chk("illegal", 32'(illegal), 32'(q[0].ill));
            if (q[0].care) begin
                chk("operation", 32'(operation), 32'(q[0].op));
                chk("operand_1", operand_1, q[0].op1);
                chk("operand_2", operand_2, q[0].op2);
            end
        end
    endtask

    // One clock of traffic: check at the falling edge, drive, advance model at the rising edge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2, input logic ordy,
                        output logic acc);
        logic cons;
        exp_t tmp;
        check_model();
        in_valid = iv; instruction = ins; pc = p; rs1_data = r1; rs2_data = r2; out_ready = ordy;
        acc  = iv && (q.size() < 2);
        cons = ordy && (q.size() > 0);
        @(posedge clk);
        if (cons) begin
            tmp = q.pop_front();
            popped.push_back(tmp.rd);
        end
        if (acc) q.push_back(model(ins, p, r1, r2));
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r = $urandom();
        int          sel = $urandom_range(0, 9);
        int          k = $urandom_range(0, 3);
        if (sel <= 2) r[6:0] = 7'h33;
        else if (sel <= 5) r[6:0] = 7'h13;
        else if (sel == 6) r[6:0] = 7'h37;
        else if (sel == 7) r[6:0] = 7'h17;
        if (sel <= 5 && k <= 1) r[31:25] = 7'h00;
        else if (sel <= 5 && k == 2) r[31:25] = 7'h20;
        return r;
    endfunction

    vec_t vecs[10];

    initial begin
        logic acc;
        logic cv;
        vecs[0] = '{32'hFFF08293, 32'h0, 32'd10, 32'd0, '{Add, 32'd10, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b1}};
        vecs[1] = '{32'h401101B3, 32'h0, 32'd7, 32'd9, '{Subtract, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0, 1'b1}};
        vecs[2] = '{32'h40325213, 32'h0, 32'h80000000, 32'd0, '{Shift_Right_Arithmetic, 32'h80000000, 32'd3, 5'd4, 1'b1, 1'b0, 1'b1}};
        vecs[3] = '{32'h123450B7, 32'h0, 32'd55, 32'd66, '{Add, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0, 1'b1}};
        vecs[4] = '{32'h00001117, 32'h100, 32'd55, 32'd66, '{Add, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0, 1'b1}};
        vecs[5] = '{32'h00000073, 32'h200, 32'd1, 32'd2, '{Add, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1}};
        vecs[6] = '{32'h00208033, 32'h0, 32'd3, 32'd4, '{Add, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, 1'b1}};
        vecs[7] = '{32'h0083B333, 32'h0, 32'd1, 32'd2, '{Set_Less_Than_Unsigned, 32'd1, 32'd2, 5'd6, 1'b1, 1'b0, 1'b1}};
        vecs[8] = '{32'h02208033, 32'h0, 32'd1, 32'd2, '{Add, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0}};
        vecs[9] = '{32'h40109093, 32'h0, 32'd1, 32'd2, '{Add, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1, 1'b0}};

        // Reset state
        #3;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset operation", 32'(operation), 32'(Add));
        chk("reset operand_1", operand_1, 32'd0);
        chk("reset operand_2", operand_2, 32'd0);
        chk("reset rd", 32'(rd), 32'd0);
        chk("reset write_enable", 32'(write_enable), 32'd0);
        chk("reset illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, one instruction per cycle with out_ready high
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].ins, vecs[i].pc, vecs[i].r1, vecs[i].r2, 1'b1, acc);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d rd", i), 32'(rd), 32'(vecs[i].e.rd));
            chk($sformatf("vec%0d write_enable", i), 32'(write_enable), 32'(vecs[i].e.we));
            chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'(vecs[i].e.ill));
            if (vecs[i].e.care) begin
                chk($sformatf("vec%0d operation", i), 32'(operation), 32'(vecs[i].e.op));
                chk($sformatf("vec%0d operand_1", i), operand_1, vecs[i].e.op1);
                chk($sformatf("vec%0d operand_2", i), operand_2, vecs[i].e.op2);
            end
        end
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc);

        // Back-pressure: A, B fill the buffer, C waits upstream
        popped.delete();
        step(1'b1, 32'h00100513, 32'd0, 32'd0, 32'd0, 1'b0, acc);
        chk("bp in_ready after A", 32'(in_ready), 32'd1);
        step(1'b1, 32'h00100593, 32'd0, 32'd0, 32'd0, 1'b0, acc);
        chk("bp in_ready full", 32'(in_ready), 32'd0);
        step(1'b1, 32'h00100613, 32'd0, 32'd0, 32'd0, 1'b0, acc);
        chk("bp held rd A", 32'(rd), 32'd10);
        chk("bp still full", 32'(in_ready), 32'd0);
        cv = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(cv, 32'h00100613, 32'd0, 32'd0, 32'd0, 1'b1, acc);
            if (acc) cv = 1'b0;
        end
        chk("bp drained count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("bp order 0", 32'(popped[0]), 32'd10);
            chk("bp order 1", 32'(popped[1]), 32'd11);
            chk("bp order 2", 32'(popped[2]), 32'd12);
        end

        // Reset in the middle of a cycle while FULL
        step(1'b1, 32'h00100513, 32'd0, 32'd0, 32'd0, 1'b0, acc);
        step(1'b1, 32'h00100593, 32'd0, 32'd0, 32'd0, 1'b0, acc);
        chk("pre-reset full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset in_ready", 32'(in_ready), 32'd1);
        chk("async reset rd", 32'(rd), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post reset out_valid", 32'(out_valid), 32'd0);
        chk("post reset in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_ins(), $urandom(), $urandom(), $urandom(),
                 $urandom_range(0, 3) != 0, acc);
        end
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
        end
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage directly upstream of the ALU in the tiny RV32I core.
- Takes a fetched instruction, its PC and the register-file read data. Decodes OP, OP-IMM, LUI and AUIPC into an alu_operation_t plus operand_1/operand_2.
- Registers the result into a two-entry skid buffer with valid/ready handshakes on both sides, so the ALU sees registered operands and back-pressure never drops an instruction.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept; registered, depends only on state.
- instruction  input  32  raw RV32I instruction.
- pc  input  32  address of instruction.
- rs1_data  input  32  register-file value for instruction[19:15].
- rs2_data  input  32  register-file value for instruction[24:20].
- out_valid  output  1  issued entry valid.
- out_ready  input  1  ALU/writeback consumes entry.
- operation  output  alu_operation_t  ALU operation.
- operand_1  output  32  ALU operand 1.
- operand_2  output  32  ALU operand 2.
- rd  output  5  destination register.
- write_enable  output  1  write rd with ALU result.
- illegal  output  1  instruction not executable by ALU.

Behaviour:
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Output fields are held stable while out_valid && !out_ready.
- Reset (async, rst_n=0): state EMPTY, out_valid=0, in_ready=1, operation=Add, operands=0, rd=0, write_enable=0, illegal=0.
- Latency: accepted at edge N, visible with out_valid=1 after edge N (one cycle). Throughput is 1/cycle when out_ready=1.
- State machine (main register M, skid register S):
  - EMPTY: in_ready=1, out_valid=0. On accept, load M and go to ONE.
  - ONE: in_ready=1, out_valid=1.
    - accept && consume: load M, stay ONE.
    - accept && !consume: load S, go FULL.
    - consume only: go EMPTY.
  - FULL: in_ready=0, out_valid=1. On consume, M<=S and go ONE. in_valid is ignored.
- Ordering: strict FIFO; no instruction is duplicated or lost.
- Decode (opcode = instruction[6:0]):
  - OP 0110011: operand_1=rs1, operand_2=rs2.
    - funct3 map: 000 Add (Subtract if funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 Xor, 101 SRL (SRA if funct7=0100000), 110 Or, 111 And.
    - Any other funct7 sets illegal.
  - OP-IMM 0010011: operand_1=rs1, operand_2=sign-extended I-immediate.
    - Same funct3 map; funct3=000 is always Add.
    - Shifts: operand_2={27'b0,shamt}. SLLI requires funct7=0. SRLI/SRAI select on funct7 0000000/0100000. Anything else sets illegal.
  - LUI 0110111: Add, operand_1=0, operand_2={imm[31:12],12'b0}.
  - AUIPC 0010111: Add, operand_1=pc, operand_2={imm[31:12],12'b0}.
  - Any other opcode: illegal=1, operation=Add, operands=0.
- write_enable = !illegal && rd!=0. rd is always instruction[11:7].
- Decode is combinational on the input side. Only decoded fields are stored; raw instruction is not.
- Reset while FULL or ONE discards both entries immediately.

Decomposition:
- Shared package: alu_operation_t and its enumerators stay in alu_operations.
- New package riscv_opcodes holds:
  - opcode constants: OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC;
  - funct7 constants: FUNCT7_BASE=0000000, FUNCT7_ALT=0100000;
  - packed struct issue_entry_t {operation, operand_1, operand_2, rd, write_enable, illegal}.
- One sub-module: immediate_generator (instruction -> I/U immediates and shamt, combinational).

Test Plan:
- Reset release: out_valid=0, in_ready=1. Then ADDI x5,x1,-1 (0xFFF08293), rs1=10, out_ready=1 -> next cycle Add, op1=10, op2=0xFFFFFFFF, rd=5, write_enable=1.
- SUB x3,x2,x1 (0x401101B3), rs1=7, rs2=9 -> Subtract, op1=7, op2=9. SRAI x4,x4,3 (0x40325213) -> Shift_Right_Arithmetic, op2=3.
- LUI x1,0x12345 (0x123450B7) -> Add, op1=0, op2=0x12345000. AUIPC x2,1 (0x00001117), pc=0x100 -> op1=0x100, op2=0x1000.
- Back-pressure:
  - Drive out_ready=0 and send A, B, C back-to-back.
  - A and B accepted; in_ready=0 in cycle 3; C is held upstream.
  - Raise out_ready: outputs A, B, C in order, no duplicates.
- ECALL (0x00000073) -> illegal=1, write_enable=0. ADD x0,x1,x2 (0x00208033) -> illegal=0, write_enable=0.
- Assert rst_n=0 mid-cycle while FULL -> out_valid drops immediately. After release: EMPTY, in_ready=1, no stale output.
